// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types for the MEM-stage memory port.
// Contents:
//   lc3b_word        - 16-bit machine word
//   mem_port_state_t - memory port controller states
//   BE_WORD          - byte-enable pattern for a full-word access
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_port_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;

endpackage : lc3b_types

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for LC-3b word/byte accesses (purely combinational).
// Ports:
//   byte_sel    in   1 = byte access, 0 = word access
//   addr_lsb    in   byte address bit 0 (selects the high lane when 1)
//   store_data  in   pipeline store data; byte stores use [7:0]
//   raw_rdata   in   raw 16-bit word returned by memory
//   byte_enable out  [1] high byte, [0] low byte
//   lane_wdata  out  write data replicated onto the addressed lane
//   fmt_rdata   out  load data, byte loads zero-extended
module mem_byte_lane
  import lc3b_types::*;
(
  input  logic       byte_sel,
  input  logic       addr_lsb,
  input  lc3b_word   store_data,
  input  lc3b_word   raw_rdata,
  output logic [1:0] byte_enable,
  output lc3b_word   lane_wdata,
  output lc3b_word   fmt_rdata
);

  // Select lanes and format data for the current access width.
  always_comb begin
    byte_enable = BE_WORD;
    lane_wdata  = store_data;
    fmt_rdata   = raw_rdata;
    if (byte_sel) begin
      // Memory picks the lane via byte_enable, so both lanes carry the byte.
      lane_wdata = {store_data[7:0], store_data[7:0]};
      if (addr_lsb) begin
        byte_enable = 2'b10;
        fmt_rdata   = {8'h00, raw_rdata[15:8]};
      end else begin
        byte_enable = 2'b01;
        fmt_rdata   = {8'h00, raw_rdata[7:0]};
      end
    end else begin
      byte_enable = BE_WORD;
      lane_wdata  = store_data;
      fmt_rdata   = raw_rdata;
    end
  end

endmodule : mem_byte_lane

// File: rtl/mem_port_ctrl.sv
// MEM-stage data memory port: accepts one LC-3b load/store at a time,
// runs it over the physical-memory strobe/resp handshake, returns the
// formatted result with a one-cycle mem_resp pulse, stalls the pipeline
// meanwhile and bounds the wait for memory with a watchdog.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   mem_read/mem_write/mem_byte      pipeline request strobes and width
//   mem_address/mem_wdata            byte address and store data
//   mem_rdata/mem_resp/stall         load data, completion pulse, stall
//   pmem_read/pmem_write             memory strobes
//   pmem_address/pmem_wdata          word-aligned address, write data
//   pmem_byte_enable                 write lane enables
//   pmem_rdata/pmem_resp             memory read data, completion
//   err_timeout/err_proto            sticky error flags
module mem_port_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       mem_byte,
  input  lc3b_word   mem_address,
  input  lc3b_word   mem_wdata,
  output lc3b_word   mem_rdata,
  output logic       mem_resp,
  output logic       stall,
  output logic       pmem_read,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_word   pmem_wdata,
  output logic [1:0] pmem_byte_enable,
  input  lc3b_word   pmem_rdata,
  input  logic       pmem_resp,
  output logic       err_timeout,
  output logic       err_proto
);

  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 32'd0);
  // Count value seen in the last BUSY cycle before expiry.
  localparam logic [CNT_W-1:0] TO_LAST =
      WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 32'd1) : '0;

  mem_port_state_t  state_r, next_state_s;
  lc3b_word         addr_r, wdata_r, rdata_r;
  logic             byte_r, write_r;
  logic [CNT_W-1:0] wdog_r;
  logic             err_to_r, err_pr_r;

  logic             busy_s, accept_s, expire_s;
  logic [1:0]       lane_be_s;
  lc3b_word         lane_wdata_s, lane_rdata_s;

  assign busy_s   = (state_r == BUSY);
  assign accept_s = (state_r == IDLE) && (mem_read || mem_write);
  // pmem_resp takes priority over expiry in the same cycle.
  assign expire_s = WDOG_EN && busy_s && !pmem_resp && (wdog_r == TO_LAST);

  mem_byte_lane u_lane (
    .byte_sel    (byte_r),
    .addr_lsb    (addr_r[0]),
    .store_data  (wdata_r),
    .raw_rdata   (pmem_rdata),
    .byte_enable (lane_be_s),
    .lane_wdata  (lane_wdata_s),
    .fmt_rdata   (lane_rdata_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (mem_read || mem_write) begin
          next_state_s = BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (pmem_resp || expire_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request capture at accept; write wins when both strobes are high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      byte_r  <= 1'b0;
      write_r <= 1'b0;
    end else if (accept_s) begin
      addr_r  <= mem_address;
      wdata_r <= mem_wdata;
      byte_r  <= mem_byte;
      write_r <= mem_write;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      byte_r  <= byte_r;
      write_r <= write_r;
    end
  end

  // Watchdog: counts BUSY cycles without pmem_resp, cleared elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_r <= '0;
    end else if (busy_s && !pmem_resp && !expire_s && WDOG_EN) begin
      wdog_r <= wdog_r + CNT_W'(1);
    end else begin
      wdog_r <= '0;
    end
  end

  // Load data register: holds until the next read completes or a timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_r <= 16'h0000;
    end else if (busy_s && pmem_resp && !write_r) begin
      rdata_r <= lane_rdata_s;
    end else if (expire_s) begin
      rdata_r <= 16'h0000;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_to_r <= 1'b0;
      err_pr_r <= 1'b0;
    end else begin
      err_to_r <= err_to_r | expire_s;
      err_pr_r <= err_pr_r | (accept_s & mem_read & mem_write);
    end
  end

  // Strobes and lanes decode from the state register, so reset drops them at once.
  assign pmem_read        = busy_s & ~write_r;
  assign pmem_write       = busy_s & write_r;
  assign pmem_address     = {addr_r[15:1], 1'b0};
  assign pmem_byte_enable = (busy_s && write_r) ? lane_be_s : 2'b00;
  assign pmem_wdata       = (busy_s && write_r) ? lane_wdata_s : 16'h0000;

  assign mem_resp    = (state_r == DONE);
  assign mem_rdata   = rdata_r;
  assign stall       = (mem_read | mem_write) & ~mem_resp;
  assign err_timeout = err_to_r;
  assign err_proto   = err_pr_r;

endmodule : mem_port_ctrl

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: directed scenarios plus randomized loads/stores
// checked against a word-addressed memory model and expected-result rules.
module tb_mem_port_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_byte = 1'b0;
  logic [15:0] mem_address = 16'h0000, mem_wdata = 16'h0000;
  logic [15:0] mem_rdata;
  logic        mem_resp, stall;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata = 16'h0000;
  logic        pmem_resp = 1'b0;
  logic        err_timeout, err_proto;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [logic [14:0]];
  logic [15:0] exp_rdata = 16'h0000;
  logic        exp_to = 1'b0;
  logic        exp_pr = 1'b0;

  mem_port_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_byte         (mem_byte),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_resp         (mem_resp),
    .stall            (stall),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp),
    .err_timeout      (err_timeout),
    .err_proto        (err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [14:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return {wa[7:0], ~wa[7:0]} ^ 16'h3C5A;
  endfunction

  // One pipeline access; lat = BUSY cycle in which memory answers, 0 = never.
  // Called with time just after a rising edge, port idle.
  task automatic access(input bit rd, input bit wr, input bit bt,
                        input logic [15:0] a, input logic [15:0] wd, input int lat);
    bit          to_exp, done;
    int          exp_cyc, cyc;
    logic [15:0] w, nw, exp_be, exp_wd;
    to_exp  = (lat == 0) || (lat > TO);
    exp_cyc = to_exp ? TO : lat;
    w       = mem_word(a[15:1]);
    exp_be  = wr ? (bt ? (a[0] ? 16'd2 : 16'd1) : 16'd3) : 16'd0;
    exp_wd  = wr ? (bt ? {wd[7:0], wd[7:0]} : wd) : 16'h0000;
    mem_read = rd; mem_write = wr; mem_byte = bt; mem_address = a; mem_wdata = wd;
    #1;
    chk("accept_stall", {15'd0, stall}, 16'd1);
    chk("accept_strobes_idle", {14'd0, pmem_read, pmem_write}, 16'd0);
    if (rd && wr) exp_pr = 1'b1;
    cyc = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      pmem_resp  = 1'b0;
      pmem_rdata = 16'($urandom);
      if (mem_resp) begin
        done = 1;
        if (to_exp) begin
          exp_rdata = 16'h0000;
          exp_to    = 1'b1;
        end else if (wr) begin
          nw = w;
          if (!bt) nw = wd;
          else if (a[0]) nw[15:8] = wd[7:0];
          else nw[7:0] = wd[7:0];
          mem_m[a[15:1]] = nw;
        end else begin
          exp_rdata = bt ? {8'h00, (a[0] ? w[15:8] : w[7:0])} : w;
        end
        chk("strobe_cycles", 16'(cyc), 16'(exp_cyc));
        chk("mem_rdata", mem_rdata, exp_rdata);
        chk("done_stall", {15'd0, stall}, 16'd0);
        chk("done_strobes", {14'd0, pmem_read, pmem_write}, 16'd0);
        chk("done_lanes", {pmem_byte_enable, 14'd0} | pmem_wdata, 16'd0);
        chk("err_timeout", {15'd0, err_timeout}, {15'd0, exp_to});
        chk("err_proto", {15'd0, err_proto}, {15'd0, exp_pr});
      end else begin
        cyc++;
        chk("busy_strobes", {14'd0, pmem_read, pmem_write}, {14'd0, rd & ~wr, wr});
        chk("busy_address", pmem_address, a & 16'hFFFE);
        chk("busy_byte_enable", {14'd0, pmem_byte_enable}, exp_be);
        chk("busy_wdata", pmem_wdata, exp_wd);
        chk("busy_stall", {15'd0, stall}, 16'd1);
        if (cyc == lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = w;
        end
      end
    end
    chk("resp_bound", {15'd0, done}, 16'd1);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("resp_single_pulse", {15'd0, mem_resp}, 16'd0);
    chk("idle_stall", {15'd0, stall}, 16'd0);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_outputs", {mem_resp, stall, pmem_read, pmem_write, pmem_byte_enable,
                        err_timeout, err_proto, 8'd0}, 16'd0);
    chk("rst_rdata", mem_rdata, 16'h0000);
    chk("rst_addr", pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, 16'h0000);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed: word read, byte write, byte reads on both lanes.
    mem_m[15'h091A] = 16'hBEEF;
    access(1, 0, 0, 16'h1234, 16'h0000, 1);
    chk("word_read_beef", mem_rdata, 16'hBEEF);
    access(0, 1, 1, 16'h2001, 16'h00A5, 3);
    chk("rdata_hold_after_write", mem_rdata, 16'hBEEF);
    mem_m[15'h1800] = 16'h7F80;
    access(1, 0, 1, 16'h3000, 16'h0000, 2);
    chk("byte_read_low", mem_rdata, 16'h0080);
    access(1, 0, 1, 16'h3001, 16'h0000, 1);
    chk("byte_read_high", mem_rdata, 16'h007F);
    // Misaligned word access and response coinciding with expiry.
    access(0, 1, 0, 16'h4445, 16'hCAFE, TO);
    access(1, 0, 0, 16'h4445, 16'h0000, 2);
    chk("misaligned_word_rd", mem_rdata, 16'hCAFE);

    // Randomized loads/stores on a small address window so reads hit writes.
    for (int n = 0; n < 60; n++) begin
      bit rw;
      rw = 1'($urandom);
      access(!rw, rw, 1'($urandom), 16'h5000 | 16'($urandom_range(0, 31)),
             16'($urandom), $urandom_range(1, TO));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Both strobes high: write wins, protocol error latched.
    access(1, 1, 0, 16'h0010, 16'h1111, 2);
    access(1, 0, 0, 16'h0010, 16'h0000, 1);
    chk("proto_write_landed", mem_rdata, 16'h1111);

    // Memory never answers: watchdog expires.
    access(1, 0, 0, 16'h6000, 16'h0000, 0);
    access(1, 0, 0, 16'h1234, 16'h0000, 1);
    chk("err_timeout_sticky", {15'd0, err_timeout}, 16'd1);

    // Reset in the middle of a write.
    mem_write = 1'b1; mem_address = 16'h7002; mem_wdata = 16'h5555;
    @(posedge clk); #1;
    chk("pre_rst_write", {15'd0, pmem_write}, 16'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_strobe_drop", {14'd0, pmem_write, pmem_read}, 16'd0);
    chk("async_resp_low", {15'd0, mem_resp}, 16'd0);
    chk("async_err_clear", {14'd0, err_timeout, err_proto}, 16'd0);
    mem_write = 1'b0;
    exp_rdata = 16'h0000; exp_to = 1'b0; exp_pr = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {15'd0, mem_resp}, 16'd0);
    access(1, 0, 0, 16'h1234, 16'h0000, 2);
    chk("post_rst_read", mem_rdata, 16'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_port_ctrl
